// File: rtl/cos_req_arbiter_if.sv
// Client request/result lines and cos accelerator start/ready handshake,
// bundled so the arbiter, its clients and the accelerator share one port.
interface cos_req_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*16-1:0] x_in;
  logic [NREQ*8-1:0]  y_in;
  logic [NREQ-1:0]    done;
  logic               err;
  logic [15:0]        result;
  logic               busy;
  logic               acc_st;
  logic [15:0]        acc_x;
  logic [7:0]         acc_y;
  logic               acc_ready;
  logic [15:0]        acc_cos;

  modport master (
    output req, x_in, y_in, acc_ready, acc_cos,
    input  done, err, result, busy, acc_st, acc_x, acc_y
  );

  modport slave (
    input  req, x_in, y_in, acc_ready, acc_cos,
    output done, err, result, busy, acc_st, acc_x, acc_y
  );
endinterface

// File: rtl/cos_req_arbiter.sv
// Round-robin scheduler sharing one cos(x) accelerator among NREQ requesters,
// with a watchdog that aborts a hung operation and flags err alongside done.
module cos_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  cos_req_arbiter_if.slave  bus
);
  localparam int          GW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_LOW  = 3'd2,
    S_WAIT_HIGH = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [GW-1:0]   rr_ptr_r, rr_ptr_s;
  logic [GW-1:0]   gid_r, gid_s;
  logic [GW-1:0]   gnt_s;
  logic [GW:0]     gnt_off_s, gnt_sum_s;
  logic [NREQ-1:0] req_rot_s;
  logic            gnt_valid_s, grant_s, waiting_s, timeout_s;
  logic [15:0]     wd_r, wd_s;
  logic [NREQ-1:0] done_r, done_s;
  logic            err_r, err_s;
  logic [15:0]     result_r, result_s;
  logic            busy_r, busy_s;
  logic            acc_st_r, acc_st_s;
  logic [15:0]     acc_x_r, acc_x_s;
  logic [7:0]      acc_y_r, acc_y_s;

  // Rotate requests so bit 0 is rr_ptr, pick the lowest set bit, rotate back.
  always_comb begin
    req_rot_s   = NREQ'({bus.req, bus.req} >> rr_ptr_r);
    gnt_off_s   = '0;
    gnt_valid_s = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      gnt_off_s   = req_rot_s[k] ? (GW+1)'(k) : gnt_off_s;
      gnt_valid_s = gnt_valid_s | req_rot_s[k];
    end
    gnt_sum_s = {1'b0, rr_ptr_r} + gnt_off_s;
    gnt_s     = (gnt_sum_s >= (GW+1)'(NREQ)) ? GW'(gnt_sum_s - (GW+1)'(NREQ))
                                              : GW'(gnt_sum_s);
  end

  assign grant_s   = (state_r == S_IDLE) && gnt_valid_s && bus.acc_ready;
  assign waiting_s = (state_r == S_WAIT_LOW) || (state_r == S_WAIT_HIGH);
  // Timeout is checked before ready so a simultaneous return still aborts.
  assign timeout_s = waiting_s && (wd_r == WD_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:      state_s = grant_s ? S_LAUNCH : S_IDLE;
      S_LAUNCH:    state_s = S_WAIT_LOW;
      S_WAIT_LOW:  state_s = timeout_s ? S_DONE :
                             (!bus.acc_ready ? S_WAIT_HIGH : S_WAIT_LOW);
      S_WAIT_HIGH: state_s = (timeout_s || bus.acc_ready) ? S_DONE : S_WAIT_HIGH;
      S_DONE:      state_s = S_IDLE;
      default:     state_s = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath, keyed off the next state.
  always_comb begin
    busy_s   = (state_s != S_IDLE);
    acc_st_s = (state_s == S_LAUNCH);
    done_s   = (state_s == S_DONE) ? ({{(NREQ-1){1'b0}}, 1'b1} << gid_r) : '0;
    err_s    = (state_s == S_DONE) && timeout_s;
    result_s = (state_s == S_DONE) ? (timeout_s ? 16'h0000 : bus.acc_cos) : result_r;
    gid_s    = grant_s ? gnt_s : gid_r;
    acc_x_s  = grant_s ? bus.x_in[{gnt_s, 4'h0} +: 16] : acc_x_r;
    acc_y_s  = grant_s ? bus.y_in[{gnt_s, 3'h0} +: 8] : acc_y_r;
    rr_ptr_s = (state_r != S_DONE) ? rr_ptr_r :
               ((gid_r == GW'(NREQ - 1)) ? '0 : gid_r + GW'(1));
    wd_s     = (state_r == S_LAUNCH) ? 16'h0000 :
               (waiting_s ? wd_r + 16'h0001 : wd_r);
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r   <= 1'b0;
      acc_st_r <= 1'b0;
      done_r   <= '0;
      err_r    <= 1'b0;
      result_r <= 16'h0000;
      gid_r    <= '0;
      acc_x_r  <= 16'h0000;
      acc_y_r  <= 8'h00;
      rr_ptr_r <= '0;
      wd_r     <= 16'h0000;
    end else begin
      busy_r   <= busy_s;
      acc_st_r <= acc_st_s;
      done_r   <= done_s;
      err_r    <= err_s;
      result_r <= result_s;
      gid_r    <= gid_s;
      acc_x_r  <= acc_x_s;
      acc_y_r  <= acc_y_s;
      rr_ptr_r <= rr_ptr_s;
      wd_r     <= wd_s;
    end
  end

  assign bus.done   = done_r;
  assign bus.err    = err_r;
  assign bus.result = result_r;
  assign bus.busy   = busy_r;
  assign bus.acc_st = acc_st_r;
  assign bus.acc_x  = acc_x_r;
  assign bus.acc_y  = acc_y_r;
endmodule

// File: tb/tb_cos_req_arbiter.sv
// Scoreboard bench for cos_req_arbiter: request batches are ordered by a
// round-robin model, a scripted accelerator replies, a monitor checks each done.
module tb_cos_req_arbiter;
  localparam int NREQ = 4;
  localparam int TO   = 24;

  typedef struct {
    int          gid;
    logic [15:0] x;
    logic [7:0]  y;
    int          d1;
    int          d2;
    logic [15:0] cos;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cos_req_arbiter_if #(.NREQ(NREQ)) bus ();
  cos_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  op_t         exp_q[$];
  op_t         acc_q[$];
  op_t         mon_e;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_launch = -100;
  int          launch_cnt = 0;
  int          issue_cnt[NREQ];
  int          done_cnt[NREQ];
  int          mrr = 0;
  logic        acc_rdy = 1'b1;
  logic        stall = 1'b0;
  logic        acc_active = 1'b0;
  logic        hold_chk = 1'b0;
  logic [15:0] last_res = 16'h0000;

  assign bus.acc_ready = acc_rdy & ~stall;

  always_comb begin
    bus.req = '0;
    for (int i = 0; i < NREQ; i++) bus.req[i] = (issue_cnt[i] != done_cnt[i]);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_done"},   32'(bus.done),   32'h0);
    check({tag, "_err"},    32'(bus.err),    32'h0);
    check({tag, "_result"}, 32'(bus.result), 32'h0);
    check({tag, "_busy"},   32'(bus.busy),   32'h0);
    check({tag, "_acc_st"}, 32'(bus.acc_st), 32'h0);
    check({tag, "_acc_x"},  32'(bus.acc_x),  32'h0);
    check({tag, "_acc_y"},  32'(bus.acc_y),  32'h0);
  endtask

  // Scripted accelerator: ready drops d1 cycles after start, returns at d2.
  initial begin
    op_t a;
    bus.acc_cos = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.acc_st && !rst && acc_q.size() != 0) begin
        a = acc_q.pop_front();
        acc_active = 1'b1;
        repeat (a.d1) @(negedge clk);
        acc_rdy     = 1'b0;
        bus.acc_cos = 16'($urandom);
        repeat (a.d2 - a.d1) @(negedge clk);
        acc_rdy     = 1'b1;
        bus.acc_cos = a.cos;
        acc_active  = 1'b0;
      end
    end
  end

  // Monitor: checks launches and completions against the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.acc_st) begin
        launch_cnt++;
        check("acc_st_single_pulse", 32'(cyc - last_launch > 1), 32'h1);
        last_launch = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_launch", 32'h1, 32'h0);
        end else begin
          check("acc_x", 32'(bus.acc_x), 32'(exp_q[0].x));
          check("acc_y", 32'(bus.acc_y), 32'(exp_q[0].y));
        end
      end
      if (bus.done != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_onehot", 32'(bus.done), 32'h1 << mon_e.gid);
          check("result", 32'(bus.result), (mon_e.d2 < TO) ? 32'(mon_e.cos) : 32'h0);
          check("err", 32'(bus.err), (mon_e.d2 < TO) ? 32'h0 : 32'h1);
          check("latency", 32'(cyc - last_launch),
                (mon_e.d2 < TO) ? 32'(mon_e.d2 + 1) : 32'(TO + 1));
          check("busy_at_done", 32'(bus.busy), 32'h1);
          last_res = (mon_e.d2 < TO) ? mon_e.cos : 16'h0000;
          done_cnt[mon_e.gid]++;
        end
        hold_chk = 1'b1;
      end else if (hold_chk) begin
        check("result_held", 32'(bus.result), 32'(last_res));
        check("busy_after_done", 32'(bus.busy), 32'h0);
        hold_chk = 1'b0;
      end else begin
        hold_chk = 1'b0;
      end
    end
  end

  // Queue one batch of requests in model rotation order, then wait for it to drain.
  task automatic run_batch(input logic [NREQ-1:0] set, input int d1f, input int d2f,
                           input bit fix, input logic [15:0] fx, input logic [7:0] fy,
                           input int stall_cyc);
    op_t o;
    int  idx, last, lc, bound, n, start;
    n     = 0;
    last  = mrr;
    start = mrr;
    for (int i = 0; i < NREQ; i++) begin
      if (set[i]) begin
        bus.x_in[16*i +: 16] = fix ? fx : 16'($urandom);
        bus.y_in[8*i +: 8]   = fix ? fy : 8'($urandom);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      idx = (start + k) % NREQ;
      if (set[idx]) begin
        o.gid = idx;
        o.x   = bus.x_in[16*idx +: 16];
        o.y   = bus.y_in[8*idx +: 8];
        o.d1  = (d1f > 0) ? d1f : $urandom_range(1, 3);
        if (d2f > 0)                        o.d2 = d2f;
        else if ($urandom_range(0, 9) < 7) o.d2 = $urandom_range(o.d1 + 1, TO - 1);
        else                                o.d2 = $urandom_range(TO, TO + 5);
        o.cos = 16'($urandom);
        exp_q.push_back(o);
        acc_q.push_back(o);
        n++;
        last = idx;
      end
    end
    mrr = (last + 1) % NREQ;
    if (stall_cyc > 0) stall = 1'b1;
    lc = launch_cnt;
    for (int i = 0; i < NREQ; i++) if (set[i]) issue_cnt[i]++;
    if (stall_cyc > 0) begin
      repeat (stall_cyc) @(negedge clk);
      check("stall_no_launch", 32'(launch_cnt), 32'(lc));
      stall = 1'b0;
    end
    bound = 100 * n + 50;
    while (exp_q.size() != 0 && bound > 0) begin
      @(negedge clk);
      bound--;
    end
    check("batch_drain", 32'(exp_q.size()), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    op_t o;
    int  lc, bound;
    bus.x_in = '0;
    bus.y_in = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("post_reset");

    // Single request, then fairness 0,1,2,3,0.
    run_batch(4'b0001, 2, 20, 1'b1, 16'h0800, 8'h10, 0);
    run_batch(4'b1111, 0, 0, 1'b0, 16'h0, 8'h0, 0);
    run_batch(4'b0001, 0, 0, 1'b0, 16'h0, 8'h0, 0);
    // Skip and wrap: move pointer to 3, then 0101 serves 0 then 2, then 1001 serves 3 first.
    run_batch(4'b0100, 0, 0, 1'b0, 16'h0, 8'h0, 0);
    run_batch(4'b0101, 0, 0, 1'b0, 16'h0, 8'h0, 0);
    run_batch(4'b1001, 0, 0, 1'b0, 16'h0, 8'h0, 0);
    // Accelerator busy in IDLE holds off the launch.
    run_batch(4'b0010, 0, 0, 1'b0, 16'h0, 8'h0, 12);
    // Hung accelerator, timeout coinciding with ready, and the last in-time return.
    run_batch(4'b0100, 2, TO + 6, 1'b0, 16'h0, 8'h0, 0);
    run_batch(4'b1000, 2, TO, 1'b0, 16'h0, 8'h0, 0);
    run_batch(4'b0001, 2, TO - 1, 1'b0, 16'h0, 8'h0, 0);

    // Reset while waiting for ready high.
    o.gid = 1; o.x = 16'($urandom); o.y = 8'($urandom); o.d1 = 2; o.d2 = 20; o.cos = 16'($urandom);
    bus.x_in[16 +: 16] = o.x;
    bus.y_in[8 +: 8]   = o.y;
    exp_q.push_back(o);
    acc_q.push_back(o);
    lc = launch_cnt;
    issue_cnt[1]++;
    bound = 50;
    while (launch_cnt == lc && bound > 0) begin
      @(negedge clk);
      bound--;
    end
    check("rst_test_launch", 32'(launch_cnt), 32'(lc + 1));
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("mid_op_reset");
    exp_q.delete();
    issue_cnt[1] = done_cnt[1];
    mrr = 0;
    bound = 60;
    while (acc_active && bound > 0) begin
      @(negedge clk);
      bound--;
    end
    check("acc_idle_before_release", 32'(acc_active), 32'h0);
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lc = launch_cnt;
    repeat (10) @(negedge clk);
    check("no_launch_after_reset", 32'(launch_cnt), 32'(lc));
    run_batch(4'b1111, 0, 0, 1'b0, 16'h0, 8'h0, 0);

    // Randomized batches.
    for (int b = 0; b < 25; b++) begin
      run_batch(4'($urandom_range(1, 15)), 0, 0, 1'b0, 16'h0, 8'h0,
                ($urandom_range(0, 5) == 0) ? 4 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cos_req_arbiter.md
Name: cos_req_arbiter

Overview:
- Round-robin scheduler that shares one cos(x) accelerator (start/ready handshake, 16-bit x, 8-bit y, 16-bit result) among NREQ requesters.
- Registers the winning requester's operands, pulses the accelerator start, and tracks its ready handshake.
- Returns the result to the winner with a one-cycle done strobe.
- A watchdog aborts a hung operation and flags an error.
- Sits between client logic and the cos accelerator top.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 255, maximum cycles from start pulse to result before abort (1..65535).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  request per requester; held with operands stable until that requester's done.
- x_in  input  NREQ*16  x operand per requester, slice i = bits [16i+15:16i].
- y_in  input  NREQ*8  y operand per requester, slice i = bits [8i+7:8i].
- done  output  NREQ  one-cycle completion strobe for the served requester.
- err  output  1  one-cycle strobe, coincident with done, when the operation timed out.
- result  output  16  cos result; valid while any done bit is high, held afterwards.
- busy  output  1  high from grant until the DONE cycle inclusive.
- acc_st  output  1  accelerator start pulse.
- acc_x  output  16  registered x to accelerator.
- acc_y  output  8  registered y to accelerator.
- acc_ready  input  1  accelerator ready (high = idle or finished).
- acc_cos  input  16  accelerator result.

Behaviour:
Reset (async, rst=1):
- state=IDLE; rr_ptr=0.
- done=0, err=0, result=0, busy=0, acc_st=0, acc_x=0, acc_y=0, watchdog=0.
- Reset mid-operation abandons the operation silently: no done, no err.

States:
- IDLE: if any req and acc_ready=1, grant the first asserted req scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - Latch gid, acc_x=x_in[gid], acc_y=y_in[gid]; busy=1; go LAUNCH.
  - If acc_ready=0, stay IDLE regardless of req.
- LAUNCH: acc_st=1 for exactly this cycle; watchdog cleared to 0; go WAIT_LOW.
- WAIT_LOW: when acc_ready=0, go WAIT_HIGH.
- WAIT_HIGH: when acc_ready=1, result<=acc_cos, go DONE.
- DONE: done[gid]=1 for one cycle; rr_ptr<=(gid+1) mod NREQ; busy=1 this cycle; next IDLE, busy=0.

Watchdog:
- Increments every cycle in WAIT_LOW and WAIT_HIGH.
- On reaching TIMEOUT, go DONE with result<=0 and err=1 alongside done[gid].
- If ready returns in the same cycle the watchdog reaches TIMEOUT, the timeout wins.

Timing and handshake rules:
- Minimum latency, req to done: IDLE grant (cycle 0), LAUNCH (1), WAIT_LOW sees ready low (2), WAIT_HIGH sees ready high (N), done at N+1.
- acc_x and acc_y are stable from LAUNCH through DONE; operand changes on x_in/y_in after grant are ignored.
- Requester drops req mid-operation: the operation still completes and done[gid] still pulses.
- A requester holding req after its done is re-granted only after higher-rotation requesters are served.
- At most one done bit is ever high; no grant occurs while busy=1.
- A new grant is possible in the IDLE cycle right after DONE, so there are 0 dead cycles between back-to-back operations.
- rr_ptr wraps from NREQ-1 to 0.

Test Plan:
- Single request: req=4'b0001, x_in[0]=16'h0800, y_in[0]=8'h10, accelerator model (ready low 2 cycles after st, high after 20) -> acc_st one pulse 1 cycle after grant; acc_x=16'h0800; done=4'b0001 with result=acc_cos, err=0.
- Round-robin fairness: req=4'b1111 held, each served once -> grant order 0,1,2,3,0; exactly one done bit per operation.
- Skip and wrap: rr_ptr=3, req=4'b0101 -> requester 0 served first, then 2; rr_ptr ends at 3.
- Busy accelerator: acc_ready held 0 in IDLE with req=4'b0010 -> no acc_st until acc_ready=1; then normal launch.
- Timeout: TIMEOUT=8, ready never returns high -> done[gid] and err both pulse 8 cycles after WAIT_LOW entry; result=16'h0000; next request served normally.
- Reset mid-op: assert rst during WAIT_HIGH -> all outputs 0 immediately with no clock edge required; no done after release; rr_ptr=0.
